// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
package hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    // RUN: normal issue, HAZ: multi-cycle hazard hold,
    // DWAIT: D-cache miss freeze, IWAIT: I-cache miss bubbling.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HAZ   = 2'd1,
        ST_DWAIT = 2'd2,
        ST_IWAIT = 2'd3
    } state_t;

    // Remaining hold cycles; the worst hazard needs 2 cycles.
    typedef logic [1:0] hold_t;

    // One bundle of pipeline controls so each output set is a single constant.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic stall;
        logic idex_write;
        logic exmem_write;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                      stall: 1'b1, idex_write: 1'b0, exmem_write: 1'b0};
    localparam ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                      stall: 1'b0, idex_write: 1'b1, exmem_write: 1'b1};
    localparam ctrl_t CTRL_HOLD   = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                      stall: 1'b1, idex_write: 1'b1, exmem_write: 1'b1};
    localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                      stall: 1'b0, idex_write: 1'b0, exmem_write: 1'b0};
    localparam ctrl_t CTRL_IWAIT  = '{pc_write: 1'b0, ifid_write: 1'b1, ifid_flush: 1'b1,
                                      stall: 1'b0, idex_write: 1'b1, exmem_write: 1'b1};

    // Larger of two hold requirements.
    function automatic hold_t need_max(input hold_t a, input hold_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// ICACHE_stall / DCACHE_stall are "not ready" flags: while one is high the
// corresponding access has not completed and the pipe must not consume it;
// the cycle it drops, the access result is valid and the pipe moves on.
interface hazard_ctrl_if #(
    parameter int REG_AW = hazard_ctrl_pkg::REG_AW,
    parameter int CNT_W  = 16
);
    import hazard_ctrl_pkg::*;

    logic [5:0]        ID_Opcode;
    logic [REG_AW-1:0] ID_Rs;
    logic [REG_AW-1:0] ID_Rt;
    logic              ID_UsesRt;
    logic              EX_MemRead;
    logic              EX_RegWrite;
    logic [REG_AW-1:0] EX_WriteReg;
    logic              MEM_MemRead;
    logic [REG_AW-1:0] MEM_WriteReg;
    logic              branch_taken;
    logic              Jump;
    logic              ICACHE_stall;
    logic              DCACHE_stall;

    logic              PC_write;
    logic              IFID_write;
    logic              IFID_flush;
    logic              stall;
    logic              IDEX_write;
    logic              EXMEM_write;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_count;

    state_t            dbg_state;
    hold_t             dbg_hold_cnt;

    modport master (
        output ID_Opcode, ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_RegWrite,
               EX_WriteReg, MEM_MemRead, MEM_WriteReg, branch_taken, Jump,
               ICACHE_stall, DCACHE_stall,
        input  PC_write, IFID_write, IFID_flush, stall, IDEX_write, EXMEM_write,
               stall_cycles, flush_count, dbg_state, dbg_hold_cnt
    );

    modport slave (
        input  ID_Opcode, ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_RegWrite,
               EX_WriteReg, MEM_MemRead, MEM_WriteReg, branch_taken, Jump,
               ICACHE_stall, DCACHE_stall,
        output PC_write, IFID_write, IFID_flush, stall, IDEX_write, EXMEM_write,
               stall_cycles, flush_count, dbg_state, dbg_hold_cnt
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] r_q;

    // Count enabled cycles, holding once the maximum is reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use / branch-operand hazard holds,
// cache-miss freeze and bubbling, control-transfer flush, perf counters.
module hazard_ctrl #(
    parameter int REG_AW = hazard_ctrl_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    import hazard_ctrl_pkg::*;

    state_t r_state;
    hold_t  r_hold_cnt;

    logic   w_is_br;
    logic   w_ex_rs;
    logic   w_ex_rt;
    logic   w_mem_rs;
    logic   w_mem_rt;
    hold_t  w_need_lu;
    hold_t  w_need_br;
    hold_t  w_need;
    state_t w_eff;
    state_t w_next;
    hold_t  w_hold_next;
    ctrl_t  w_ctrl;
    ctrl_t  w_out;

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    assign w_is_br  = (hz.ID_Opcode == OP_BEQ) || (hz.ID_Opcode == OP_BNE);
    assign w_ex_rs  = (hz.EX_WriteReg  != {REG_AW{1'b0}}) && (hz.EX_WriteReg  == hz.ID_Rs);
    assign w_ex_rt  = (hz.EX_WriteReg  != {REG_AW{1'b0}}) && (hz.EX_WriteReg  == hz.ID_Rt);
    assign w_mem_rs = (hz.MEM_WriteReg != {REG_AW{1'b0}}) && (hz.MEM_WriteReg == hz.ID_Rs);
    assign w_mem_rt = (hz.MEM_WriteReg != {REG_AW{1'b0}}) && (hz.MEM_WriteReg == hz.ID_Rt);

    // Hold cycles required by the instruction sitting in ID.
    always_comb begin
        w_need_lu = 2'd0;
        w_need_br = 2'd0;
        if (hz.EX_MemRead && (w_ex_rs || (w_ex_rt && hz.ID_UsesRt))) begin
            w_need_lu = 2'd1;
        end
        // Branches compare in ID, so they also wait for ALU results and MEM loads.
        if (w_is_br) begin
            if (hz.EX_MemRead && (w_ex_rs || w_ex_rt)) begin
                w_need_br = 2'd2;
            end else if ((hz.EX_RegWrite && (w_ex_rs || w_ex_rt)) ||
                         (hz.MEM_MemRead && (w_mem_rs || w_mem_rt))) begin
                w_need_br = 2'd1;
            end
        end
        w_need = need_max(w_need_lu, w_need_br);
    end

    // A wait state whose stall has just dropped behaves as the state it
    // resumes into, so the pipe restarts in the same cycle the cache is ready.
    always_comb begin
        w_eff = r_state;
        if ((r_state == ST_DWAIT) && !hz.DCACHE_stall) begin
            w_eff = (r_hold_cnt != 2'd0) ? ST_HAZ : ST_RUN;
        end else if ((r_state == ST_IWAIT) && !hz.ICACHE_stall) begin
            w_eff = ST_RUN;
        end
    end

    // Next state and the output set for this cycle. Outputs depend on the
    // current inputs because a hazard must hold the pipe in the cycle it appears.
    always_comb begin
        w_ctrl      = CTRL_NORMAL;
        w_next      = ST_RUN;
        w_hold_next = r_hold_cnt;
        if (hz.DCACHE_stall) begin
            w_ctrl = CTRL_FREEZE;
            w_next = ST_DWAIT;
        end else begin
            case (w_eff)
                ST_HAZ: begin
                    w_ctrl      = CTRL_HOLD;
                    w_hold_next = r_hold_cnt - 2'd1;
                    w_next      = (r_hold_cnt > 2'd1) ? ST_HAZ : ST_RUN;
                end
                ST_IWAIT: begin
                    w_ctrl = CTRL_IWAIT;
                    w_next = ST_IWAIT;
                end
                default: begin
                    if (w_need != 2'd0) begin
                        w_ctrl      = CTRL_HOLD;
                        w_hold_next = w_need - 2'd1;
                        w_next      = (w_need > 2'd1) ? ST_HAZ : ST_RUN;
                    end else if (hz.ICACHE_stall) begin
                        // IWAIT set already flushes IF/ID, covering a taken branch too.
                        w_ctrl = CTRL_IWAIT;
                        w_next = ST_IWAIT;
                    end else begin
                        w_ctrl            = CTRL_NORMAL;
                        w_ctrl.ifid_flush = hz.branch_taken || hz.Jump;
                    end
                end
            endcase
        end
    end

    // Reset overrides the decoded controls immediately, not at the next edge.
    assign w_out = rst ? w_ctrl : CTRL_RESET;

    // Sequencing state: current mode and outstanding hold cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RUN;
            r_hold_cnt <= 2'd0;
        end else begin
            r_state    <= w_next;
            r_hold_cnt <= w_hold_next;
        end
    end

    assign hz.PC_write     = w_out.pc_write;
    assign hz.IFID_write   = w_out.ifid_write;
    assign hz.IFID_flush   = w_out.ifid_flush;
    assign hz.stall        = w_out.stall;
    assign hz.IDEX_write   = w_out.idex_write;
    assign hz.EXMEM_write  = w_out.exmem_write;
    assign hz.dbg_state    = r_state;
    assign hz.dbg_hold_cnt = r_hold_cnt;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (!w_out.pc_write),
        .q   (hz.stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_out.ifid_flush),
        .q   (hz.flush_count)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a cycle-level model.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    typedef struct packed {
        logic       rst;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       ex_mr;
        logic       ex_rw;
        logic [4:0] ex_wr;
        logic       mem_mr;
        logic [4:0] mem_wr;
        logic       bt;
        logic       jmp;
        logic       ic;
        logic       dc;
    } stim_t;

    localparam logic [5:0] V_RESET  = 6'b000100;
    localparam logic [5:0] V_NORMAL = 6'b110011;
    localparam logic [5:0] V_FLUSH  = 6'b111011;
    localparam logic [5:0] V_HOLD   = 6'b000111;
    localparam logic [5:0] V_FREEZE = 6'b000000;
    localparam logic [5:0] V_IWAIT  = 6'b011011;

    logic clk;
    logic rst_n;

    hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus ();
    hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  bus_s ();

    hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst_n),
        .hz  (bus)
    );

    hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut_small (
        .clk (clk),
        .rst (rst_n),
        .hz  (bus_s)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    int m_holds  = 0;   // bubble cycles still owed by an earlier hazard
    bit m_iwait  = 0;   // an I-cache miss is being waited out
    int m_stalls = 0;   // cycles with PC_write low since reset
    int m_flush  = 0;   // cycles with IFID_flush high since reset

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Hold cycles demanded by the ID instruction, straight from the hazard rules.
    function automatic int need_cycles(input stim_t s);
        bit is_br, ex_rs, ex_rt, mem_rs, mem_rt;
        int n;
        is_br  = (s.op == 6'd4) || (s.op == 6'd5);
        ex_rs  = (s.ex_wr != 0) && (s.ex_wr == s.rs);
        ex_rt  = (s.ex_wr != 0) && (s.ex_wr == s.rt);
        mem_rs = (s.mem_wr != 0) && (s.mem_wr == s.rs);
        mem_rt = (s.mem_wr != 0) && (s.mem_wr == s.rt);
        n = 0;
        if (s.ex_mr && (ex_rs || (ex_rt && s.uses_rt))) n = 1;
        if (is_br && s.ex_mr && (ex_rs || ex_rt)) n = 2;
        else if (is_br && ((s.ex_rw && (ex_rs || ex_rt)) || (s.mem_mr && (mem_rs || mem_rt))))
            n = (n > 1) ? n : 1;
        return n;
    endfunction

    // Expected control vector for this cycle; advances the model's bookkeeping.
    function automatic logic [5:0] model_ctrl(input stim_t s);
        int n;
        if (!s.rst) return V_RESET;
        if (s.dc) begin
            m_iwait = 0;
            return V_FREEZE;
        end
        if (m_holds > 0) begin
            m_holds--;
            return V_HOLD;
        end
        if (m_iwait && s.ic) return V_IWAIT;
        m_iwait = 0;
        n = need_cycles(s);
        if (n > 0) begin
            m_holds = n - 1;
            return V_HOLD;
        end
        if (s.ic) begin
            m_iwait = 1;
            return V_IWAIT;
        end
        return (s.bt || s.jmp) ? V_FLUSH : V_NORMAL;
    endfunction

    // ---------------- driver ----------------
    task automatic drive_one(input stim_t s);
        rst_n                 = s.rst;
        bus.ID_Opcode         = s.op;
        bus.ID_Rs             = s.rs;
        bus.ID_Rt             = s.rt;
        bus.ID_UsesRt         = s.uses_rt;
        bus.EX_MemRead        = s.ex_mr;
        bus.EX_RegWrite       = s.ex_rw;
        bus.EX_WriteReg       = s.ex_wr;
        bus.MEM_MemRead       = s.mem_mr;
        bus.MEM_WriteReg      = s.mem_wr;
        bus.branch_taken      = s.bt;
        bus.Jump              = s.jmp;
        bus.ICACHE_stall      = s.ic;
        bus.DCACHE_stall      = s.dc;
        bus_s.ID_Opcode       = s.op;
        bus_s.ID_Rs           = s.rs;
        bus_s.ID_Rt           = s.rt;
        bus_s.ID_UsesRt       = s.uses_rt;
        bus_s.EX_MemRead      = s.ex_mr;
        bus_s.EX_RegWrite     = s.ex_rw;
        bus_s.EX_WriteReg     = s.ex_wr;
        bus_s.MEM_MemRead     = s.mem_mr;
        bus_s.MEM_WriteReg    = s.mem_wr;
        bus_s.branch_taken    = s.bt;
        bus_s.Jump            = s.jmp;
        bus_s.ICACHE_stall    = s.ic;
        bus_s.DCACHE_stall    = s.dc;
    endtask

    // One clock cycle: drive after the edge, check mid-cycle, update the model.
    task automatic step(input stim_t s);
        logic [5:0] exp_v;
        logic [5:0] got_v;
        @(posedge clk);
        #1;
        drive_one(s);
        @(negedge clk);
        if (!s.rst) begin
            m_holds  = 0;
            m_iwait  = 0;
            m_stalls = 0;
            m_flush  = 0;
        end
        check("stall_cycles", 32'(bus.stall_cycles), 32'(sat(m_stalls, 16'hFFFF)));
        check("flush_count", 32'(bus.flush_count), 32'(sat(m_flush, 16'hFFFF)));
        check("stall_cycles_w4", 32'(bus_s.stall_cycles), 32'(sat(m_stalls, 15)));
        check("flush_count_w4", 32'(bus_s.flush_count), 32'(sat(m_flush, 15)));
        exp_v = model_ctrl(s);
        got_v = {bus.PC_write, bus.IFID_write, bus.IFID_flush,
                 bus.stall, bus.IDEX_write, bus.EXMEM_write};
        check("ctrl", 32'(got_v), 32'(exp_v));
        if (s.rst) begin
            if (!exp_v[5]) m_stalls++;
            if (exp_v[3])  m_flush++;
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s     = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s         = idle();
        s.rst     = ($urandom_range(0, 299) != 0);
        s.op      = ($urandom_range(0, 1) == 0) ? 6'(4 + $urandom_range(0, 1)) : 6'($urandom_range(0, 63));
        s.rs      = 5'($urandom_range(0, 3));
        s.rt      = 5'($urandom_range(0, 3));
        s.uses_rt = 1'($urandom_range(0, 1));
        s.ex_mr   = ($urandom_range(0, 3) == 0);
        s.ex_rw   = 1'($urandom_range(0, 1));
        s.ex_wr   = 5'($urandom_range(0, 3));
        s.mem_mr  = ($urandom_range(0, 3) == 0);
        s.mem_wr  = 5'($urandom_range(0, 3));
        s.bt      = ($urandom_range(0, 3) == 0);
        s.jmp     = ($urandom_range(0, 7) == 0);
        s.ic      = ($urandom_range(0, 5) == 0);
        s.dc      = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        stim_t s;
        int    snap;
        drive_one('0);

        // Reset held for two cycles, then release.
        step('0);
        step('0);
        step(idle());
        check("state_after_reset", 32'(bus.dbg_state), 32'(ST_RUN));

        // Load-use: lw $3 in EX, add reading $3 in ID.
        s = idle(); s.ex_mr = 1; s.ex_rw = 1; s.ex_wr = 5'd3; s.rs = 5'd3;
        step(s);
        step(idle());
        check("lu_stall_cycles", 32'(bus.stall_cycles), 32'd1);

        // beq on $4 with lw $4 in EX: two holds.
        s = idle(); s.op = OP_BEQ; s.rs = 5'd4; s.uses_rt = 1; s.ex_mr = 1; s.ex_rw = 1; s.ex_wr = 5'd4;
        step(s);
        step(s);
        step(idle());
        // beq on $4 with add $4 in EX: one hold.
        s = idle(); s.op = OP_BEQ; s.rs = 5'd4; s.uses_rt = 1; s.ex_rw = 1; s.ex_wr = 5'd4;
        step(s);
        step(idle());

        // D-cache miss arriving while one hold is still owed.
        s = idle(); s.op = OP_BNE; s.rt = 5'd4; s.uses_rt = 1; s.ex_mr = 1; s.ex_rw = 1; s.ex_wr = 5'd4;
        step(s);
        s = idle(); s.dc = 1;
        for (int i = 0; i < 3; i++) step(s);
        step(idle());
        check("dc_resume_hold", 32'(bus.PC_write), 32'd0);
        step(idle());

        // I-cache miss for two cycles.
        snap = int'(bus.stall_cycles);
        s = idle(); s.ic = 1;
        step(s);
        step(s);
        step(idle());
        check("ic_stall_delta", 32'(int'(bus.stall_cycles) - snap), 32'd2);

        // Taken branch with no hazard flushes once.
        snap = int'(bus.flush_count);
        s = idle(); s.op = OP_BEQ; s.bt = 1;
        step(s);
        step(idle());
        check("br_flush_delta", 32'(int'(bus.flush_count) - snap), 32'd1);
        // Taken branch behind a load-use hazard: no flush while holding.
        s = idle(); s.op = 6'h00; s.bt = 1; s.ex_mr = 1; s.ex_wr = 5'd3; s.rs = 5'd3;
        step(s);
        check("no_flush_in_hold", 32'(bus.IFID_flush), 32'd0);
        step(idle());
        // Taken branch together with an I-cache miss.
        s = idle(); s.op = OP_BEQ; s.bt = 1; s.ic = 1;
        step(s);
        s = idle(); s.ic = 1;
        step(s);
        step(idle());

        // Reset in the middle of a D-cache freeze.
        s = idle(); s.dc = 1;
        step(s);
        step(s);
        s.rst = 0;
        step(s);
        check("rst_mid_dwait_ctrl", 32'({bus.PC_write, bus.IFID_write, bus.IFID_flush,
                                          bus.stall, bus.IDEX_write, bus.EXMEM_write}), 32'(V_RESET));
        step(idle());
        check("rst_mid_dwait_state", 32'(bus.dbg_state), 32'(ST_RUN));
        check("rst_mid_dwait_cnt", 32'(bus.stall_cycles), 32'd0);

        // Randomized traffic; the narrow instance saturates its counters here.
        for (int i = 0; i < 3000; i++) step(rand_stim());
        step(idle());

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core; drives the `stall` input of the ID stage (bubble insertion into ID/EX) and the write-enables/flushes of PC, IF/ID, ID/EX and EX/MEM.
- Detects load-use and branch-operand hazards, and freezes or bubbles the pipe around I-cache and D-cache miss handshakes.
- Flushes IF/ID on taken branch or jump, and keeps saturating stall/flush performance counters.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- ID_Opcode  in  6  opcode of the instruction in ID.
- ID_Rs  in  REG_AW  Rs of the instruction in ID.
- ID_Rt  in  REG_AW  Rt of the instruction in ID.
- ID_UsesRt  in  1  the ID instruction reads Rt (R-type, beq, bne, sw).
- EX_MemRead  in  1  EX-stage instruction is a load.
- EX_RegWrite  in  1  EX-stage instruction writes a register.
- EX_WriteReg  in  REG_AW  destination register in EX.
- MEM_MemRead  in  1  MEM-stage instruction is a load.
- MEM_WriteReg  in  REG_AW  destination register in MEM.
- branch_taken  in  1  ID branch resolved taken.
- Jump  in  1  ID instruction is a jump.
- ICACHE_stall  in  1  instruction fetch not ready.
- DCACHE_stall  in  1  data access not ready.
- PC_write  out  1  PC update enable.
- IFID_write  out  1  IF/ID register enable.
- IFID_flush  out  1  load NOP into IF/ID.
- stall  out  1  zero ID control signals (bubble) into ID/EX.
- IDEX_write  out  1  ID/EX enable.
- EXMEM_write  out  1  EX/MEM and MEM/WB enable.
- stall_cycles  out  CNT_W  saturating count of cycles with PC_write=0.
- flush_count  out  CNT_W  saturating count of IFID_flush cycles.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN, hold_cnt=0, both counters 0.
  - Outputs forced: PC_write=0, IFID_write=0, IDEX_write=0, EXMEM_write=0, stall=1, IFID_flush=0.
- Register 0 never causes a hazard (any match on WriteReg=0 is ignored).
- Hazard detect (combinational, evaluated in RUN only):
  - LU (load-use): EX_MemRead and EX_WriteReg matches Rs, or matches Rt with ID_UsesRt. Needs 1 cycle.
  - BR (ID_Opcode 000100 or 000101):
    - EX_MemRead with match on Rs/Rt → 2 cycles.
    - Otherwise, EX_RegWrite with match, or MEM_MemRead with MEM_WriteReg match → 1 cycle.
  - Needed N = max over the conditions above.
- States:
  - RUN:
    - DCACHE_stall has top priority → go to DWAIT.
    - Otherwise N>0 → assert HOLD outputs this cycle, set hold_cnt=N-1, go to HAZ if N-1>0, else stay in RUN.
    - Otherwise ICACHE_stall → assert IWAIT outputs, go to IWAIT.
    - Otherwise normal flow.
  - HAZ: HOLD outputs; hold_cnt decrements; leave to RUN when it reaches 0. DCACHE_stall in HAZ → go to DWAIT, keeping hold_cnt.
  - DWAIT: FREEZE outputs while DCACHE_stall=1. On release, return to HAZ if hold_cnt>0, else RUN.
  - IWAIT: IWAIT outputs while ICACHE_stall=1, then RUN. DCACHE_stall in IWAIT → DWAIT.
- Output sets:
  - Normal: all writes=1, stall=0.
  - HOLD: PC_write=0, IFID_write=0, stall=1, IDEX_write=1, EXMEM_write=1.
  - FREEZE: all writes=0, stall=0, IFID_flush=0.
  - IWAIT: PC_write=0, IFID_write=1, IFID_flush=1, stall=0, others=1.
- IFID_flush on control transfer:
  - Asserted for one cycle when (branch_taken or Jump) in RUN with N=0 and no D-cache stall.
  - Suppressed in HOLD and FREEZE; the branch re-resolves after the hold.
  - Simultaneous branch_taken and ICACHE_stall: flush and hold the PC, then enter IWAIT.
- Counters:
  - stall_cycles increments on every cycle with PC_write=0 after reset.
  - flush_count increments on every IFID_flush cycle.
  - Both saturate at all-ones.
- Reset mid-HAZ or mid-DWAIT: immediate return to the reset values above; no residual hold.

Decomposition:
- Shared package holds:
  - opcode constants OP_BEQ=6'b000100, OP_BNE=6'b000101;
  - state encoding RUN/HAZ/DWAIT/IWAIT;
  - REG_AW.
- One sub-module, `sat_counter` (CNT_W, inc → q), instantiated twice for the counters.

Test Plan:
- lw $3 in EX (EX_MemRead=1, EX_WriteReg=3) with add using Rs=3 in ID → exactly 1 cycle of PC_write=0, IFID_write=0, stall=1; then Normal; stall_cycles=1.
- beq Rs=4 in ID with lw $4 in EX → 2 HOLD cycles (HAZ visited); with add $4 in EX instead → 1 HOLD cycle.
- DCACHE_stall high 3 cycles during HAZ with hold_cnt=1 → 3 FREEZE cycles (all writes 0), then 1 HOLD cycle, then RUN.
- ICACHE_stall high 2 cycles, no hazards → IFID_flush=1 and PC_write=0 for 2 cycles; stall_cycles=2.
- branch_taken=1, no hazard → IFID_flush=1 for one cycle, flush_count=1; with branch_taken=1 and an LU hazard → no flush during HOLD.
- rst pulled low mid-DWAIT → outputs at reset values immediately; after release, state RUN and counters 0. Force stall_cycles to 0xFFFF → it stays 0xFFFF.
